// File: rtl/crypto_ahb_pkg.sv
// Shared types and address map for the crypto AHB-Lite write initiator.
package crypto_ahb_pkg;

    // AHB-Lite transfer types as driven on HTRANS.
    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_t;

    // Master sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEY_A  = 3'd1,
        ST_KEY_D  = 3'd2,
        ST_ADR_A  = 3'd3,
        ST_ADR_D  = 3'd4,
        ST_STREAM = 3'd5,
        ST_STALL  = 3'd6,
        ST_DONE   = 3'd7
    } mst_state_t;

    // Slave register map, relative to the slave base address.
    localparam logic [31:0] KEY_OFS  = 32'h0000_0000;
    localparam logic [31:0] ADDR_OFS = 32'h0000_0010;
    localparam logic [31:0] PKT_OFS  = 32'h0000_0020;

    // Each packet occupies one 128-bit word.
    localparam int PKT_BYTES = 16;

endpackage

// File: rtl/ahb_pkt_counter.sv
// Remaining-packet down-counter with zero flag, plus the packet address pointer.
module ahb_pkt_counter
    import crypto_ahb_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             step,
    output logic             zero,
    output logic [31:0]      pkt_addr
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;

    // Load restarts the count and points at the first packet slot; each step
    // consumes one packet and moves the pointer to the next 16-byte slot.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (load) begin
            cnt_d  = load_cnt;
            addr_d = BASE_ADDR + PKT_OFS;
        end else if (step) begin
            cnt_d  = cnt_q - CNT_W'(1);
            addr_d = addr_q + 32'(PKT_BYTES);
        end
    end

    // Counter and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    assign zero     = (cnt_q == '0);
    assign pkt_addr = addr_q;

endmodule

// File: rtl/crypto_ahb_master.sv
// AHB-Lite write initiator: key write, SRAM-address write, then a packet stream
// with BUSY transfers inserted whenever the upstream source stalls.
module crypto_ahb_master
    import crypto_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     key,
    input  logic [31:0]      sram_addr,
    input  logic [CNT_W-1:0] num_packets,
    input  logic [127:0]     pkt_data,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    input  logic             HREADY,
    output logic             HSELx,
    output logic             HWRITE,
    output logic [1:0]       HTRANS,
    output logic [31:0]      HADDR,
    output logic [127:0]     HWDATA,
    output logic             busy,
    output logic             done
);

    mst_state_t   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [31:0]  sram_addr_q, sram_addr_d;
    logic [127:0] wdata_q, wdata_d;
    logic         hsel_q, hsel_d;
    htrans_t      htrans_q, htrans_d;
    logic [31:0]  haddr_q, haddr_d;
    logic [127:0] hwdata_q, hwdata_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         cnt_load;
    logic         cnt_step;
    logic         cnt_zero;
    logic [31:0]  pkt_addr;

    ahb_pkt_counter #(
        .CNT_W     (CNT_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load && HREADY),
        .load_cnt (num_packets),
        .step     (cnt_step && HREADY),
        .zero     (cnt_zero),
        .pkt_addr (pkt_addr)
    );

    // Next-state and next-output decode; bus outputs are registered, so each
    // state's decode appears on the bus one cycle later.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        hsel_d      = 1'b0;
        htrans_d    = HT_IDLE;
        haddr_d     = '0;
        hwdata_d    = '0;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_step    = 1'b0;
        pkt_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (num_packets != '0)) begin
                    key_d       = key;
                    sram_addr_d = sram_addr;
                    cnt_load    = 1'b1;
                    state_d     = ST_KEY_A;
                end
            end
            ST_KEY_A: begin
                hsel_d   = 1'b1;
                htrans_d = HT_NONSEQ;
                haddr_d  = BASE_ADDR + KEY_OFS;
                state_d  = ST_KEY_D;
            end
            ST_KEY_D: begin
                // Deselected here: the slave's WAIT state advances on any
                // selected write, so the key data phase must be unselected.
                hwdata_d = key_q;
                state_d  = ST_ADR_A;
            end
            ST_ADR_A: begin
                hsel_d   = 1'b1;
                htrans_d = HT_NONSEQ;
                haddr_d  = BASE_ADDR + ADDR_OFS;
                state_d  = ST_ADR_D;
            end
            ST_ADR_D, ST_STREAM, ST_STALL: begin
                // Data phase of the previous transfer.
                hwdata_d = (state_q == ST_ADR_D) ? {96'b0, sram_addr_q} : wdata_q;
                // Address phase of the next transfer.
                if (!cnt_zero) begin
                    hsel_d = 1'b1;
                    if (pkt_valid) begin
                        htrans_d  = HT_SEQ;
                        haddr_d   = pkt_addr;
                        pkt_ready = HREADY && !rst;
                        wdata_d   = pkt_data;
                        cnt_step  = 1'b1;
                        state_d   = ST_STREAM;
                    end else begin
                        htrans_d = HT_BUSY;
                        haddr_d  = haddr_q;
                        state_d  = ST_STALL;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; a low HREADY freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            sram_addr_q <= '0;
            wdata_q     <= '0;
            hsel_q      <= 1'b0;
            htrans_q    <= HT_IDLE;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (HREADY) begin
            state_q     <= state_d;
            key_q       <= key_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            hsel_q      <= hsel_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign HSELx  = hsel_q;
    assign HWRITE = hsel_q;
    assign HTRANS = htrans_q;
    assign HADDR  = haddr_q;
    assign HWDATA = hwdata_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
